// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port data memory (combinational read,
// synchronous write) between the load/store unit (requester 0) and the
// debug/program-loader port (requester 1). Arbitration is round-robin with
// bounded locking. Read data is registered into a one-cycle response pulse
// routed to the requester that issued the read.
module mem_arbiter #(
    parameter int AddressWidth = 10,
    parameter int DataWidth    = 32,
    parameter int MaxLock      = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    req0_valid_i,
    output logic                    req0_ready_o,
    input  logic                    req0_we_i,
    input  logic                    req0_lock_i,
    input  logic [AddressWidth-1:0] req0_addr_i,
    input  logic [DataWidth-1:0]    req0_wdata_i,
    output logic                    req0_rvalid_o,
    output logic [DataWidth-1:0]    req0_rdata_o,

    input  logic                    req1_valid_i,
    output logic                    req1_ready_o,
    input  logic                    req1_we_i,
    input  logic                    req1_lock_i,
    input  logic [AddressWidth-1:0] req1_addr_i,
    input  logic [DataWidth-1:0]    req1_wdata_i,
    output logic                    req1_rvalid_o,
    output logic [DataWidth-1:0]    req1_rdata_o,

    output logic                    mem_wr_en_o,
    output logic [AddressWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0]    mem_wr_data_o,
    input  logic [DataWidth-1:0]    mem_r_data_i
);

    localparam int              CntW   = $clog2(MaxLock + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxLock);

    // Lock counter increment that sticks at MaxLock instead of wrapping.
    function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
        if (v >= MaxCnt) begin
            return MaxCnt;
        end
        return v + CntW'(1);
    endfunction

    logic                    last_q,     last_d;
    logic                    owner_q,    owner_d;
    logic                    lock_act_q, lock_act_d;
    logic [CntW-1:0]         lock_cnt_q, lock_cnt_d;
    logic [1:0]              rvalid_q,   rvalid_d;
    logic [DataWidth-1:0]    rdata_q0,   rdata_d0;
    logic [DataWidth-1:0]    rdata_q1,   rdata_d1;

    logic                    gnt_vld;
    logic                    gnt_idx;
    logic                    gnt_we;
    logic                    gnt_lock;
    logic [AddressWidth-1:0] gnt_addr;
    logic [DataWidth-1:0]    gnt_wdata;

    // Grant selection: the lock only matters when both requesters contend;
    // nothing is granted while reset is held.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 1'b0;
        if (rst_ni) begin
            if (req0_valid_i && req1_valid_i) begin
                gnt_vld = 1'b1;
                if (lock_act_q && (lock_cnt_q < MaxCnt)) begin
                    gnt_idx = owner_q;
                end else begin
                    gnt_idx = ~last_q;
                end
            end else if (req0_valid_i) begin
                gnt_vld = 1'b1;
                gnt_idx = 1'b0;
            end else if (req1_valid_i) begin
                gnt_vld = 1'b1;
                gnt_idx = 1'b1;
            end
        end
    end

    assign gnt_we    = gnt_idx ? req1_we_i    : req0_we_i;
    assign gnt_lock  = gnt_idx ? req1_lock_i  : req0_lock_i;
    assign gnt_addr  = gnt_idx ? req1_addr_i  : req0_addr_i;
    assign gnt_wdata = gnt_idx ? req1_wdata_i : req0_wdata_i;

    assign req0_ready_o  = gnt_vld & ~gnt_idx;
    assign req1_ready_o  = gnt_vld &  gnt_idx;

    // Memory port is driven to zero when idle so it never sees stale traffic.
    assign mem_wr_en_o   = gnt_vld & gnt_we;
    assign mem_addr_o    = gnt_vld ? gnt_addr  : '0;
    assign mem_wr_data_o = gnt_vld ? gnt_wdata : '0;

    assign req0_rvalid_o = rvalid_q[0];
    assign req1_rvalid_o = rvalid_q[1];
    assign req0_rdata_o  = rdata_q0;
    assign req1_rdata_o  = rdata_q1;

    // Next-state: round-robin pointer, lock tracking and read response capture.
    always_comb begin
        last_d     = last_q;
        owner_d    = owner_q;
        lock_act_d = lock_act_q;
        lock_cnt_d = lock_cnt_q;
        rvalid_d   = 2'b00;
        rdata_d0   = rdata_q0;
        rdata_d1   = rdata_q1;
        if (gnt_vld) begin
            last_d = gnt_idx;
            if (gnt_lock) begin
                owner_d    = gnt_idx;
                lock_act_d = 1'b1;
                if (lock_act_q && (owner_q == gnt_idx)) begin
                    lock_cnt_d = sat_inc(lock_cnt_q);
                end else begin
                    lock_cnt_d = CntW'(1);
                end
            end else begin
                lock_act_d = 1'b0;
                lock_cnt_d = '0;
            end
            if (!gnt_we) begin
                rvalid_d[gnt_idx] = 1'b1;
                if (gnt_idx) begin
                    rdata_d1 = mem_r_data_i;
                end else begin
                    rdata_d0 = mem_r_data_i;
                end
            end
        end else begin
            lock_act_d = 1'b0;
            lock_cnt_d = '0;
        end
    end

    // State register; last_q resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            lock_act_q <= 1'b0;
            lock_cnt_q <= '0;
            rvalid_q   <= 2'b00;
            rdata_q0   <= '0;
            rdata_q1   <= '0;
        end else begin
            last_q     <= last_d;
            owner_q    <= owner_d;
            lock_act_q <= lock_act_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid_q   <= rvalid_d;
            rdata_q0   <= rdata_d0;
            rdata_q1   <= rdata_d1;
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single-port, combinational-read, synchronous-write data memory between the core load/store unit (requester 0) and the debug/program-loader port (requester 1). It arbitrates round-robin with bounded locking, drives the memory's write-enable, address and write-data inputs, and registers the memory's combinational read data into a one-cycle read response to the granted requester. It sits between the requesters and the memory instance in the datapath top.

## Interface

- AddressWidth, 10, word-address width; matches the memory instance.
- DataWidth, 32, data width; matches the memory instance.
- MaxLock, 4, maximum consecutive locked grants under contention; must be at least 1.

- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- reqN_valid_i  input  1  requester N (N = 0, 1) has an access pending.
- reqN_ready_o  output  1  access accepted this cycle (valid & ready).
- reqN_we_i  input  1  1 = write, 0 = read.
- reqN_lock_i  input  1  request to keep the grant on the next contended cycle.
- reqN_addr_i  input  AddressWidth  word address.
- reqN_wdata_i  input  DataWidth  write data.
- reqN_rvalid_o  output  1  one-cycle pulse: read data for requester N is on reqN_rdata_o.
- reqN_rdata_o  output  DataWidth  registered read data; holds until the next read response to N.
- mem_wr_en_o  output  1  to memory write enable.
- mem_addr_o  output  AddressWidth  to memory address.
- mem_wr_data_o  output  DataWidth  to memory write data.
- mem_r_data_i  input  DataWidth  from memory combinational read data.

## Operation

- State: last_q (last granted requester), lock_act_q, owner_q, lock_cnt_q (width $clog2(MaxLock+1)), rvalid_q[1:0], rdata_q0, rdata_q1.
- Grant (combinational, at most one per cycle):
  - no valid: no grant.
  - exactly one valid: grant it.
  - both valid: if lock_act_q and lock_cnt_q < MaxLock, grant owner_q; otherwise grant the requester that is not last_q.
- reqN_ready_o = grant to N. No other condition stalls acceptance.
- Memory drive: with a grant, mem_addr_o/mem_wr_data_o = granted requester's addr/wdata and mem_wr_en_o = granted we. With no grant: mem_wr_en_o = 0, mem_addr_o = 0, mem_wr_data_o = 0.
- On each grant: last_q <= granted index.
  - If granted lock_i = 1: owner_q <= granted; lock_cnt_q <= lock_cnt_q+1 if lock_act_q and owner_q == granted, else 1; lock_act_q <= 1.
  - If granted lock_i = 0: lock_act_q <= 0, lock_cnt_q <= 0.
- Cycle with no grant: lock_act_q <= 0, lock_cnt_q <= 0; last_q holds.
- Read grant to N: rdata_qN <= mem_r_data_i; rvalid_q[N] <= 1. Any other cycle: rvalid_q[N] <= 0.
- Write grant: memory updates at the same edge; no response pulse.
- lock_cnt_q saturates at MaxLock; it never wraps.

## Timing

- Reset (asynchronous assert, synchronous release): last_q = 1, so requester 0 wins the first contention. lock_act_q = 0, lock_cnt_q = 0, owner_q = 0, both rvalid = 0, both rdata = 0. All ready outputs and mem_wr_en_o are 0 while rst_ni is low.
- Accept: same cycle as valid when granted (combinational ready).
- Read latency: 1 cycle. Accept at edge k gives rvalid high and rdata valid during cycle k+1. Back-to-back reads by one requester give back-to-back pulses.
- Read-after-write, same address, consecutive cycles (any requesters): the read returns the new data.
- Reset mid-operation: an in-flight read response is dropped (rvalid forced 0). A write accepted at the edge coincident with reset assertion is not guaranteed.
- Locking only affects contention. An uncontested requester is always granted, regardless of lock state.

## Test plan

- Reset: hold rst_ni low with both valid = 1. Expect both ready, both rvalid, and mem_wr_en_o = 0, and both rdata = 0. Release, then contend: requester 0 is granted first.
- Single read: req0 writes 0xDEADBEEF to addr 0x005 at cycle k, then reads 0x005 at k+1. Expect req0_rvalid_o = 1 and rdata = 0xDEADBEEF at k+2, and req1_rvalid_o = 0 throughout.
- Round-robin: both valid, no lock, 6 cycles. Expect grant sequence 0,1,0,1,0,1, and each read response routed only to its requester.
- Bounded lock: MaxLock = 4, both valid, req0_lock_i = 1 held. Expect grants 0,0,0,0,1; then 0 again once req1 releases. With req1 idle, req0 is granted every cycle indefinitely.
- Cross-requester RAW: req1 writes 0x12345678 to 0x3FF at cycle k; req0 reads 0x3FF at k+1. Expect req0_rdata_o = 0x12345678 at k+2. Also check no grant at address wrap 0x3FF in the mem_addr_o drive.
- Reset mid-read: req1 read accepted at edge k, rst_ni asserted before edge k+1. Expect req1_rvalid_o = 0 immediately and rdata = 0.
